// File: rtl/mem_reader_pkg.sv
// Shared definitions for the burst reader slice. This package provides:
//   - the FSM state encoding;
//   - the output FIFO depth;
//   - the stall counter width;
//   - the non-power-of-two address wrap helper.
package mem_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Two slots are enough to absorb one in-flight read plus one stalled word.
  localparam int FIFO_DEPTH = 2;
  localparam int STALL_W    = 16;

  // Next sequential address, wrapping DEPTH-1 -> 0 by explicit compare so that
  // DEPTH does not have to be a power of two.
  function automatic int unsigned wrap_next(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/mbr_out_fifo.sv
// Two-entry synchronous FIFO carrying {last, data} for the burst reader.
// The head entry is presented combinationally. The count output is used by the
// parent for read-credit accounting. flush empties the FIFO in one cycle.
module mbr_out_fifo
  import mem_reader_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_reg [FIFO_DEPTH];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      // Write the slot addressed by the write pointer; contents need no reset.
      always_ff @(posedge clk) begin
        if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  // Pointer and occupancy tracking; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= !wr_ptr_reg;
      if (pop)  rd_ptr_reg <= !rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine for a 1-cycle-latency single-port SRAM.
//
// Operation: a command of (base, length) issues sequential reads. Addresses
// wrap at DEPTH. The words are streamed out over valid/ready with full
// back-pressure.
//
// Read credits: at most two words are ever outstanding (in flight plus
// buffered), so the 2-entry FIFO cannot overflow.
//
// Bypass path: when the FIFO is empty, the word returning from the SRAM is
// presented directly. This gives out_valid two cycles after start. If that
// word is not accepted, it is pushed into the FIFO, so the presented word
// stays stable.
//
// Optional build macro MEM_BURST_READER_PERF_EN adds a saturating stall
// counter. Without it, stall_cnt is tied to zero.
module mem_burst_reader
  import mem_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              abort,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  issue_cnt_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;
  logic              done_reg;

  logic              issue;
  logic              issue_is_last;
  logic              abort_hit;
  logic              out_fire;
  logic [2:0]        credits_used;

  logic [DATA_W:0]   fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign addr_next     = ADDR_W'(wrap_next(32'(addr_reg), 32'(DEPTH)));
  assign abort_hit     = abort && (state_reg != ST_IDLE);
  assign credits_used  = {1'b0, fifo_count} + {2'b00, inflight_reg};
  assign issue         = (state_reg == ST_READ) && (credits_used < 3'(FIFO_DEPTH));
  assign issue_is_last = (issue_cnt_reg == len_reg - LEN_W'(1));

  assign fifo_empty = (fifo_count == 2'd0);
  assign out_valid  = !fifo_empty || inflight_reg;
  assign out_data   = !fifo_empty  ? fifo_head[DATA_W-1:0] :
                      inflight_reg ? mem_rdata : '0;
  assign out_last   = !fifo_empty ? fifo_head[DATA_W] : (inflight_reg && inflight_last_reg);
  assign out_fire   = out_valid && out_ready;

  // A returning word goes to the FIFO unless it is consumed straight off the
  // bypass path; the FIFO pops only when it was the one presenting the word.
  assign fifo_push = inflight_reg && !(fifo_empty && out_ready);
  assign fifo_pop  = out_fire && !fifo_empty;

  assign mem_re   = issue;
  assign mem_addr = addr_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;

  mbr_out_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort_hit),
    .push      (fifo_push),
    .push_data ({inflight_last_reg, mem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Command FSM, read issue and in-flight tracking; abort discards the in-flight read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      addr_reg          <= '0;
      len_reg           <= '0;
      issue_cnt_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
    end else begin
      done_reg          <= 1'b0;
      inflight_reg      <= issue;
      inflight_last_reg <= issue && issue_is_last;
      if (abort_hit) begin
        state_reg         <= ST_IDLE;
        inflight_reg      <= 1'b0;
        inflight_last_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start) begin
              if (length != '0) begin
                state_reg     <= ST_READ;
                addr_reg      <= base_addr;
                len_reg       <= length;
                issue_cnt_reg <= '0;
              end else begin
                done_reg <= 1'b1;
              end
            end
          end
          ST_READ: begin
            if (issue) begin
              addr_reg      <= addr_next;
              issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
              if (issue_is_last) state_reg <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (out_fire && out_last) begin
              state_reg <= ST_IDLE;
              done_reg  <= 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MEM_BURST_READER_PERF_EN
  logic [STALL_W-1:0] stall_cnt_reg;

  // Count back-pressured cycles, saturating; a start accepted in IDLE clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (start && (state_reg == ST_IDLE)) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed testbench for mem_burst_reader. It models a 1-cycle-latency SRAM
// whose content is a fixed function of the address. Inputs are driven and
// outputs sampled on the falling clock edge. Honours MEM_BURST_READER_PERF_EN.
module tb_mem_burst_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LEN_W  = 11;
`ifdef MEM_BURST_READER_PERF_EN
  localparam int EXP_STALL = 5;
`else
  localparam int EXP_STALL = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [15:0]       stall_cnt;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_burst_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  function automatic logic [31:0] word_at(input int a);
    return 32'hD000_0000 + 32'(a) * 32'h0000_1001;
  endfunction

  // SRAM model: registered read, data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= word_at(int'(mem_addr));
  end

  // One line per accepted stream word.
  always @(posedge clk) begin
    if (rst && out_valid && out_ready)
      $display("xfer data=%h last=%0b", out_data, out_last);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int          issued;
  int          accepted;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] held;
  bit   [3:0]  pat = 4'b1001;
  int          exp_addr [4] = '{1022, 1023, 0, 1};
  logic        done_seen;

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    out_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy), 0);
    check("rst_valid",  32'(out_valid), 0);
    check("rst_re",     32'(mem_re), 0);
    check("rst_done",   32'(done), 0);
    check("rst_addr",   32'(mem_addr), 0);
    check("rst_data",   out_data, 0);
    check("rst_stall",  32'(stall_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    // Burst 1: base 5, length 4, always ready.
    start = 1'b1; base_addr = 10'd5; length = 11'd4; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t1_c1_re", 32'(mem_re), 1);   check("t1_c1_addr", 32'(mem_addr), 5);
    check("t1_c1_valid", 32'(out_valid), 0); check("t1_c1_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_c2_addr", 32'(mem_addr), 6); check("t1_c2_data", out_data, word_at(5));
    check("t1_c2_valid", 32'(out_valid), 1); check("t1_c2_last", 32'(out_last), 0);
    @(negedge clk);
    check("t1_c3_addr", 32'(mem_addr), 7); check("t1_c3_data", out_data, word_at(6));
    @(negedge clk);
    check("t1_c4_re", 32'(mem_re), 1); check("t1_c4_addr", 32'(mem_addr), 8);
    check("t1_c4_data", out_data, word_at(7)); check("t1_c4_last", 32'(out_last), 0);
    @(negedge clk);
    check("t1_c5_re", 32'(mem_re), 0); check("t1_c5_data", out_data, word_at(8));
    check("t1_c5_last", 32'(out_last), 1); check("t1_c5_done", 32'(done), 0);
    @(negedge clk);
    check("t1_c6_done", 32'(done), 1); check("t1_c6_busy", 32'(busy), 0);
    check("t1_c6_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("t1_c7_done", 32'(done), 0);

    // Burst 2: wrap from 1022 through 0.
    start = 1'b1; base_addr = 10'd1022; length = 11'd4;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); start = 1'b0;
      if (c <= 4) check("t2_addr", 32'(mem_addr), 32'(exp_addr[c-1]));
      if (c >= 2 && c <= 5) begin
        check("t2_data", out_data, word_at(exp_addr[c-2]));
        check("t2_last", 32'(out_last), (c == 5) ? 1 : 0);
      end
      if (c == 6) check("t2_done", 32'(done), 1);
    end

    // Burst 3: length 8 with ready pattern 1,0,0,1 (scoreboard).
    start = 1'b1; base_addr = 10'd100; length = 11'd8; out_ready = pat[0];
    issued = 0; accepted = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    for (int c = 1; c < 80 && accepted < 8; c++) begin
      @(negedge clk); start = 1'b0; out_ready = pat[c % 4];
      if (mem_re) begin
        check("t3_credit", 32'((issued - accepted) < 2), 1);
        check("t3_addr", 32'(mem_addr), 32'(100 + issued));
        issued++;
      end
      if (prev_stall) begin
        check("t3_hold_data", out_data, prev_data);
        check("t3_hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        check("t3_data", out_data, word_at(100 + accepted));
        check("t3_last", 32'(out_last), (accepted == 7) ? 1 : 0);
        accepted++;
      end
      prev_stall = out_valid && !out_ready; prev_data = out_data; prev_last = out_last;
    end
    check("t3_accepted", 32'(accepted), 8);
    check("t3_issued", 32'(issued), 8);
    @(negedge clk);
    check("t3_done", 32'(done), 1); check("t3_valid_after", 32'(out_valid), 0);
    out_ready = 1'b1;

    // Zero-length command.
    start = 1'b1; base_addr = 10'd3; length = 11'd0;
    @(negedge clk); start = 1'b0;
    check("t4_done", 32'(done), 1); check("t4_re", 32'(mem_re), 0);
    check("t4_valid", 32'(out_valid), 0); check("t4_busy", 32'(busy), 0);
    @(negedge clk);
    check("t4_done_clr", 32'(done), 0); check("t4_re2", 32'(mem_re), 0);

    // Abort after the 3rd word of a length-10 burst.
    start = 1'b1; base_addr = 10'd200; length = 11'd10;
    repeat (4) begin @(negedge clk); start = 1'b0; end
    check("t5_third", out_data, word_at(202));
    @(negedge clk); abort = 1'b1; out_ready = 1'b0;
    @(negedge clk); abort = 1'b0;
    check("t5_valid", 32'(out_valid), 0); check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0); check("t5_re", 32'(mem_re), 0);
    @(negedge clk);
    check("t5_done2", 32'(done), 0); check("t5_valid2", 32'(out_valid), 0);
    start = 1'b1; base_addr = 10'd0; length = 11'd2; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    check("t5b_addr0", 32'(mem_addr), 0); check("t5b_re", 32'(mem_re), 1);
    @(negedge clk);
    check("t5b_w0", out_data, word_at(0)); check("t5b_addr1", 32'(mem_addr), 1);
    @(negedge clk);
    check("t5b_w1", out_data, word_at(1)); check("t5b_last", 32'(out_last), 1);
    @(negedge clk);
    check("t5b_valid", 32'(out_valid), 0); check("t5b_done", 32'(done), 1);

    // Abort coincident with the final handshake: no done.
    start = 1'b1; base_addr = 10'd300; length = 11'd2;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    check("t5c_last", 32'(out_last), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t5c_done", 32'(done), 0); check("t5c_busy", 32'(busy), 0);
    @(negedge clk);
    check("t5c_done2", 32'(done), 0);

    // Five stall cycles, then stall counter clear on the next start.
    start = 1'b1; base_addr = 10'd50; length = 11'd4;
    @(negedge clk); start = 1'b0;
    check("t6_clr", 32'(stall_cnt), 0);
    @(negedge clk); out_ready = 1'b0; held = out_data;
    check("t6_first", out_data, word_at(50));
    repeat (4) begin
      @(negedge clk);
      check("t6_hold", out_data, held);
    end
    @(negedge clk); out_ready = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(negedge clk);
      done_seen = done;
    end
    check("t6_done_seen", 32'(done_seen), 1);
    check("t6_stall", 32'(stall_cnt), 32'(EXP_STALL));
    start = 1'b1; length = 11'd0;
    @(negedge clk); start = 1'b0;
    check("t6_stall_clr", 32'(stall_cnt), 0);

    // Reset in the middle of a burst.
    start = 1'b1; base_addr = 10'd10; length = 11'd6;
    repeat (3) begin @(negedge clk); start = 1'b0; end
    rst = 1'b0; #1;
    check("t7_busy", 32'(busy), 0); check("t7_valid", 32'(out_valid), 0);
    check("t7_re", 32'(mem_re), 0); check("t7_data", out_data, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("t7_valid2", 32'(out_valid), 0); check("t7_done", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
